cordic_gain_comp: RTL and testbench
===================================

Name: cordic_gain_comp

Overview:
- Downstream stage of the iterative CORDIC core. Consumes its x/y/z result and one-cycle valid strobe.
- Removes the CORDIC gain by multiplying x and y by the constant GAIN (≈1/K).
- Uses a sequential shift-add multiplier: one gain bit per clock, shared by both channels.
- z passes through unchanged. The compensated result is held, and a one-cycle output strobe is issued.

Parameters:
- N_FRAC, 7: fractional bits. Data words are signed, N_FRAC+1 bits wide.
- GAIN, 8'd78: unsigned gain, N_FRAC+1 bits, value GAIN/2^N_FRAC. Default 78/128 = 0.609375 ≈ 1/1.6468.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- x_i  in  N_FRAC+1  signed x from CORDIC
- y_i  in  N_FRAC+1  signed y from CORDIC
- z_i  in  N_FRAC+1  signed residual angle from CORDIC
- data_in_valid_strobe_i  in  1  one-cycle strobe, inputs valid
- x_o  out  N_FRAC+1  signed compensated x
- y_o  out  N_FRAC+1  signed compensated y
- z_o  out  N_FRAC+1  registered copy of z_i
- data_out_valid_strobe_o  out  1  one-cycle strobe, outputs updated
- busy_o  out  1  high while a multiplication is in progress

Interface note: reset rst_i, asynchronous, active-high; clock clk_i.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, counter=0, accumulators=0, x_o=y_o=z_o=0, data_out_valid_strobe_o=0, busy_o=0.
- State IDLE:
  - On a rising edge with data_in_valid_strobe_i=1: capture x_i, y_i, z_i; clear both accumulators; counter=0; go to MUL.
  - Otherwise stay in IDLE.
- State MUL, counter k = 0..N_FRAC:
  - Each edge: accX += GAIN[k] ? (sext(x) << k) : 0; same for accY.
  - Accumulators are 2*(N_FRAC+1) bits, signed, and exact (no overflow possible).
  - If k < N_FRAC: counter increments.
  - If k == N_FRAC, on the same edge:
    - final value = (acc including the bit-N_FRAC term) >>> N_FRAC (arithmetic shift, floor, no rounding);
    - saturate to [-2^N_FRAC, 2^N_FRAC-1];
    - register into x_o/y_o;
    - z_o = captured z;
    - data_out_valid_strobe_o=1; go to IDLE.
- Strobe and latency:
  - data_out_valid_strobe_o is high for exactly one cycle and clears on the next edge.
  - Latency: strobe asserted N_FRAC+1 edges after the capture edge (8 for default).
  - Outputs hold their values until the next completion.
- busy_o = (state==MUL), registered.
- Back-to-back: an input strobe during MUL is ignored (dropped, no queuing). An input strobe in the IDLE cycle where data_out_valid_strobe_o is high is accepted. Minimum input period is N_FRAC+2 cycles.
- Saturation only occurs when GAIN ≥ 2^N_FRAC. With the default GAIN it never triggers.
- Reset mid-MUL: abort immediately. No output strobe is issued; outputs return to 0.
- Undefined state encodings return to IDLE.

Test Plan:
- Reset then idle 20 cycles → all outputs 0, strobe never asserted, busy_o=0.
- Strobe with x=127, y=-128, z=-45 (GAIN=78) → exactly 8 edges later: x_o=77, y_o=-78, z_o=-45, strobe high one cycle; busy_o high for the 8 cycles in between.
- x=-1, y=0, z=0 → x_o=-1 (floor of -78/128), y_o=0. Outputs still hold these values 10 cycles after the strobe.
- Second strobe 3 cycles after the first (x=10 then x=100) → only the first result (x_o=6) is produced, with a single output strobe; a strobe at cycle N_FRAC+2 with x=100 is accepted → x_o=60.
- Param GAIN=255: x=127 → x_o=127 (saturated from 253); y=-128 → y_o=-128 (saturated from -255).
- Assert rst_i 4 cycles into MUL, release, wait 15 cycles → no output strobe, outputs 0, busy_o=0; a new strobe afterwards computes correctly.

Source files
------------

// File: rtl/cordic_gain_comp.sv
// Gain compensation stage after the iterative CORDIC core: scales x/y by GAIN/2^N_FRAC
// with a shared bit-serial shift-add multiplier; z is passed through alongside.
module cordic_gain_comp #(
   parameter int unsigned     N_FRAC = 7,
   parameter logic [N_FRAC:0] GAIN   = 8'd78
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N_FRAC:0] x_i,
   input  logic [N_FRAC:0] y_i,
   input  logic [N_FRAC:0] z_i,
   input  logic            data_in_valid_strobe_i,
   output logic [N_FRAC:0] x_o,
   output logic [N_FRAC:0] y_o,
   output logic [N_FRAC:0] z_o,
   output logic            data_out_valid_strobe_o,
   output logic            busy_o
);

   localparam int unsigned W  = N_FRAC + 1;
   localparam int unsigned AW = 2 * W;
   localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

   localparam logic signed [AW-1:0] SAT_MAX = $signed({{(W + 1){1'b0}}, {N_FRAC{1'b1}}});
   localparam logic signed [AW-1:0] SAT_MIN = $signed({{(W + 1){1'b1}}, {N_FRAC{1'b0}}});

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [W-1:0]          x_q, x_d, y_q, y_d, z_q, z_d;
   logic signed [AW-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic [W-1:0]          xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
   logic                  strobe_q, strobe_d;
   logic                  busy_q, busy_d;

   logic signed [AW-1:0]  term_x, term_y, sum_x, sum_y, shx, shy;

   function automatic logic [W-1:0] sat(input logic signed [AW-1:0] v);
      if (v > SAT_MAX) begin
         sat = SAT_MAX[W-1:0];
      end else if (v < SAT_MIN) begin
         sat = SAT_MIN[W-1:0];
      end else begin
         sat = v[W-1:0];
      end
   endfunction

   // Partial product for the current gain bit; both channels share the counter.
   always_comb begin
      term_x = '0;
      term_y = '0;
      if (GAIN[cnt_q]) begin
         term_x = $signed({{W{x_q[W-1]}}, x_q}) <<< cnt_q;
         term_y = $signed({{W{y_q[W-1]}}, y_q}) <<< cnt_q;
      end
      sum_x = acc_x_q + term_x;
      sum_y = acc_y_q + term_y;
      shx   = sum_x >>> N_FRAC;
      shy   = sum_y >>> N_FRAC;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      acc_x_d  = acc_x_q;
      acc_y_d  = acc_y_q;
      xo_d     = xo_q;
      yo_d     = yo_q;
      zo_d     = zo_q;
      strobe_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (data_in_valid_strobe_i) begin
               x_d     = x_i;
               y_d     = y_i;
               z_d     = z_i;
               acc_x_d = '0;
               acc_y_d = '0;
               cnt_d   = '0;
               state_d = StMul;
            end
         end
         StMul: begin
            acc_x_d = sum_x;
            acc_y_d = sum_y;
            if (cnt_q == CW'(N_FRAC)) begin
               xo_d     = sat(shx);
               yo_d     = sat(shy);
               zo_d     = z_q;
               strobe_d = 1'b1;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d == StMul);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         acc_x_q  <= '0;
         acc_y_q  <= '0;
         xo_q     <= '0;
         yo_q     <= '0;
         zo_q     <= '0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         acc_x_q  <= acc_x_d;
         acc_y_q  <= acc_y_d;
         xo_q     <= xo_d;
         yo_q     <= yo_d;
         zo_q     <= zo_d;
         strobe_q <= strobe_d;
         busy_q   <= busy_d;
      end
   end

   assign x_o                     = xo_q;
   assign y_o                     = yo_q;
   assign z_o                     = zo_q;
   assign data_out_valid_strobe_o = strobe_q;
   assign busy_o                  = busy_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Scoreboard bench for cordic_gain_comp: default-gain and saturating-gain instances share stimulus.
module tb_cordic_gain_comp;

   localparam int N_FRAC  = 7;
   localparam int LAT     = N_FRAC + 2;  // drive negedge to first negedge with the strobe visible
   localparam int GAIN_A  = 78;
   localparam int GAIN_B  = 255;

   typedef struct {
      int x;
      int y;
      int z;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] x_in = '0, y_in = '0, z_in = '0;
   logic       stb_in = 1'b0;

   logic [7:0] xa, ya, za, xb, yb, zb;
   logic       stba, stbb, busya, busyb;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];

   cordic_gain_comp dut (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .x_i                     (x_in),
      .y_i                     (y_in),
      .z_i                     (z_in),
      .data_in_valid_strobe_i  (stb_in),
      .x_o                     (xa),
      .y_o                     (ya),
      .z_o                     (za),
      .data_out_valid_strobe_o (stba),
      .busy_o                  (busya)
   );

   cordic_gain_comp #(
      .N_FRAC (7),
      .GAIN   (8'd255)
   ) dut_sat (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .x_i                     (x_in),
      .y_i                     (y_in),
      .z_i                     (z_in),
      .data_in_valid_strobe_i  (stb_in),
      .x_o                     (xb),
      .y_o                     (yb),
      .z_o                     (zb),
      .data_out_valid_strobe_o (stbb),
      .busy_o                  (busyb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: floor(v*g / 2^N_FRAC), then clamp to the signed output range.
   function automatic int model(input int v, input int g);
      int p;
      int q;
      p = v * g;
      q = p >>> N_FRAC;
      if (q > (2 ** N_FRAC) - 1) q = (2 ** N_FRAC) - 1;
      if (q < -(2 ** N_FRAC)) q = -(2 ** N_FRAC);
      return q;
   endfunction

   // Called at a negedge; returns at the following negedge.
   task automatic send(input int x, input int y, input int z, input bit accept);
      exp_t e;
      x_in   = x[7:0];
      y_in   = y[7:0];
      z_in   = z[7:0];
      stb_in = 1'b1;
      if (accept) begin
         e.cyc = cyc + LAT;
         e.z   = z;
         e.x   = model(x, GAIN_A);
         e.y   = model(y, GAIN_A);
         qa.push_back(e);
         e.x   = model(x, GAIN_B);
         e.y   = model(y, GAIN_B);
         qb.push_back(e);
      end
      @(negedge clk);
      stb_in = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (stba) begin
         if (qa.size() == 0) begin
            check_eq("unexpected strobe (gain 78)", 1, 0);
         end else begin
            e = qa.pop_front();
            check_eq("latency (gain 78)", cyc, e.cyc);
            check_eq("x_o (gain 78)", int'($signed(xa)), e.x);
            check_eq("y_o (gain 78)", int'($signed(ya)), e.y);
            check_eq("z_o (gain 78)", int'($signed(za)), e.z);
         end
      end
      if (stbb) begin
         if (qb.size() == 0) begin
            check_eq("unexpected strobe (gain 255)", 1, 0);
         end else begin
            e = qb.pop_front();
            check_eq("latency (gain 255)", cyc, e.cyc);
            check_eq("x_o (gain 255)", int'($signed(xb)), e.x);
            check_eq("y_o (gain 255)", int'($signed(yb)), e.y);
            check_eq("z_o (gain 255)", int'($signed(zb)), e.z);
         end
      end
   end

   task automatic check_idle_zero(input string tag);
      check_eq({tag, " x_o"}, int'(xa), 0);
      check_eq({tag, " y_o"}, int'(ya), 0);
      check_eq({tag, " z_o"}, int'(za), 0);
      check_eq({tag, " busy_o"}, int'(busya), 0);
      check_eq({tag, " sat x_o"}, int'(xb), 0);
      check_eq({tag, " sat busy_o"}, int'(busyb), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check_idle_zero("after reset");

      // Full-scale inputs; busy held for the whole multiply.
      send(127, -128, -45, 1'b1);
      check_eq("busy during mul", int'(busya), 1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check_eq("busy during mul", int'(busya), 1);
      end
      @(negedge clk);
      check_eq("busy at completion", int'(busya), 0);
      check_eq("strobe at completion", int'(stba), 1);
      @(negedge clk);
      check_eq("strobe cleared", int'(stba), 0);

      // Negative input rounds toward minus infinity; result held afterwards.
      send(-1, 0, 0, 1'b1);
      repeat (LAT - 1 + 10) @(negedge clk);
      check_eq("hold x_o", int'($signed(xa)), -1);
      check_eq("hold y_o", int'($signed(ya)), 0);

      // Strobe during MUL dropped; strobe on the completion cycle accepted.
      send(10, 3, 5, 1'b1);
      repeat (2) @(negedge clk);
      send(20, 20, 20, 1'b0);
      repeat (5) @(negedge clk);
      send(100, -7, 9, 1'b1);
      repeat (LAT + 2) @(negedge clk);
      check_eq("x_o after back-to-back", int'($signed(xa)), model(100, GAIN_A));

      // Reset mid-multiply aborts with no output strobe.
      send(50, 50, 50, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      check_idle_zero("after mid-mul reset");

      send(-77, 33, 12, 1'b1);
      repeat (LAT + 3) @(negedge clk);
      check_eq("scoreboard drained (gain 78)", qa.size(), 0);
      check_eq("scoreboard drained (gain 255)", qb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
